// File: rtl/frame_pkg.sv
// Shared definitions for the telemetry frame receiver and its transmitter bench model.
package frame_pkg;

    localparam logic [15:0] FRAME_HEADER        = 16'hAA55;
    localparam int          FRAME_PAYLOAD_BYTES = 6;

    typedef enum logic [1:0] {
        HUNT_H,
        HUNT_L,
        PAYLOAD
    } frame_state_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/frame_rx_decoder_if.sv
// Serial line in, decoded telemetry words and strobes out.
interface frame_rx_decoder_if;

    logic        rxd;
    logic [15:0] lowest;
    logic [15:0] highest;
    logic [15:0] hitout;
    logic        frame_valid;
    logic        frame_error;

    modport master (
        output rxd,
        input  lowest, highest, hitout, frame_valid, frame_error
    );

    modport slave (
        input  rxd,
        output lowest, highest, hitout, frame_valid, frame_error
    );

endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: two-flop synchroniser, mid-bit sampling, one-cycle
// byte_valid / byte_err pulses after the stop-bit sample.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on the synchronised line
// START | half-bit wait, then confirm the start bit (high = false start)
// DATA  | sample one data bit per bit period, LSB first
// STOP  | sample the stop bit; high = good byte, low = framing error
module uart_byte_rx
    import frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       byte_err
);

    localparam int               CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic            rxd_meta;
    logic            rxd_sync;
    rx_state_t       state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic [7:0]      shreg, shreg_nxt;
    logic            valid_nxt;
    logic            err_nxt;

    // Bring the asynchronous line into the clk domain; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
        end
    end

    // Receiver state, bit timer and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            byte_valid <= valid_nxt;
            byte_err   <= err_nxt;
        end
    end

    // Bit timing: down-counter reloaded per bit, action on terminal count.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_sync) begin
                    state_nxt = START;
                    cnt_nxt   = HALF;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (rxd_sync) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = DATA;
                        cnt_nxt     = FULL;
                        bit_idx_nxt = 3'd0;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shreg_nxt = {rxd_sync, shreg[7:1]};
                    cnt_nxt   = FULL;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    valid_nxt = rxd_sync;
                    err_nxt   = !rxd_sync;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign data = shreg;

endmodule

// File: rtl/frame_rx_decoder.sv
// Telemetry frame decoder: hunts for the sync word, collects the payload and
// publishes three big-endian words with a one-cycle frame_valid strobe.
//
// state   | meaning
// HUNT_H  | waiting for the high header byte
// HUNT_L  | high header byte seen, expecting the low header byte
// PAYLOAD | collecting payload bytes; header values here are plain data
module frame_rx_decoder
    import frame_pkg::*;
#(
    parameter int          CLKS_PER_BIT  = 5208,
    parameter logic [15:0] HEADER        = FRAME_HEADER,
    parameter int          PAYLOAD_BYTES = FRAME_PAYLOAD_BYTES
) (
    input  logic                clk,
    input  logic                reset,
    frame_rx_decoder_if.slave   bus
);

    localparam logic [2:0] LAST_IDX = 3'(PAYLOAD_BYTES - 1);

    logic [7:0]    rx_data;
    logic          byte_valid;
    logic          byte_err;

    frame_state_t  state, state_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [47:0]   shadow, shadow_nxt;
    logic [47:0]   words;
    logic          load_out;
    logic          frame_valid_q, frame_valid_nxt;
    logic          frame_error_q, frame_error_nxt;

    uart_byte_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_rx (
        .clk        (clk),
        .rst_n      (reset),
        .rxd        (bus.rxd),
        .data       (rx_data),
        .byte_valid (byte_valid),
        .byte_err   (byte_err)
    );

    // Frame state, payload shadow and published words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= HUNT_H;
            idx           <= '0;
            shadow        <= '0;
            words         <= '0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            shadow        <= shadow_nxt;
            frame_valid_q <= frame_valid_nxt;
            frame_error_q <= frame_error_nxt;
            if (load_out) begin
                words <= shadow_nxt;
            end
        end
    end

    // Frame sequencing; only a received byte (good or bad) moves the FSM.
    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        shadow_nxt      = shadow;
        load_out        = 1'b0;
        frame_valid_nxt = 1'b0;
        frame_error_nxt = 1'b0;
        if (byte_valid) begin
            case (state)
                HUNT_H: begin
                    if (rx_data == HEADER[15:8]) begin
                        state_nxt = HUNT_L;
                    end
                end
                HUNT_L: begin
                    if (rx_data == HEADER[7:0]) begin
                        state_nxt  = PAYLOAD;
                        idx_nxt    = 3'd0;
                        shadow_nxt = '0;
                    end else if (rx_data != HEADER[15:8]) begin
                        state_nxt = HUNT_H;
                    end
                end
                PAYLOAD: begin
                    shadow_nxt = {shadow[39:0], rx_data};
                    if (idx == LAST_IDX) begin
                        load_out        = 1'b1;
                        frame_valid_nxt = 1'b1;
                        state_nxt       = HUNT_H;
                        idx_nxt         = 3'd0;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
                default: state_nxt = HUNT_H;
            endcase
        end else if (byte_err && state != HUNT_H) begin
            frame_error_nxt = 1'b1;
            state_nxt       = HUNT_H;
            idx_nxt         = 3'd0;
            shadow_nxt      = '0;
        end
    end

    assign bus.lowest      = words[47:32];
    assign bus.highest     = words[31:16];
    assign bus.hitout      = words[15:0];
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_error = frame_error_q;

endmodule

// File: tb/tb_frame_rx_decoder.sv
// Bench for frame_rx_decoder: table of byte streams with a scoreboard of
// expected frame events, plus hand sequences for glitch and reset-mid-frame.
module tb_frame_rx_decoder;
    import frame_pkg::*;

    localparam int CPB = 16;

    typedef struct packed {
        logic        is_err;
        logic [47:0] words;
    } exp_t;

    typedef struct {
        logic [95:0] bytes;
        int          n;
        int          err_at;
        logic        exp_valid;
        logic        exp_err;
        logic [47:0] words;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t q[$];
    vec_t vecs[7];

    frame_rx_decoder_if bus();

    frame_rx_decoder #(
        .CLKS_PER_BIT  (CPB),
        .HEADER        (16'hAA55),
        .PAYLOAD_BYTES (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_ok);
        bus.rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            bus.rxd = d[b];
            repeat (CPB) @(negedge clk);
        end
        bus.rxd = stop_ok;
        repeat (CPB) @(negedge clk);
        bus.rxd = 1'b1;
    endtask

    task automatic send_frame(input logic [63:0] f);
        for (int k = 0; k < 8; k++) begin
            send_byte(f[63-8*k -: 8], 1'b1);
        end
    endtask

    // Scoreboard: every frame strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.frame_valid && bus.frame_error) begin
                check("strobes_exclusive", 48'd1, 48'd0);
            end
            if (bus.frame_valid || bus.frame_error) begin
                if (q.size() == 0) begin
                    check("unexpected_event", {47'd0, bus.frame_error}, 48'h1_0000_0000_00);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("event_kind", {47'd0, bus.frame_error}, {47'd0, e.is_err});
                    check("event_words", {bus.lowest, bus.highest, bus.hitout}, e.words);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{{64'hAA55_1234_5678_9ABC, 32'h0}, 8, -1, 1'b1, 1'b0, 48'h1234_5678_9ABC};
        vecs[1] = '{{88'h00FF_AAAA_5500_0100_0200_03, 8'h0}, 11, -1, 1'b1, 1'b0, 48'h0001_0002_0003};
        vecs[2] = '{{64'hAA55_AA55_AA55_AA55, 32'h0}, 8, -1, 1'b1, 1'b0, 48'hAA55_AA55_AA55};
        vecs[3] = '{{64'hAA55_1234_5678_9ABC, 32'h0}, 8, -1, 1'b1, 1'b0, 48'h1234_5678_9ABC};
        vecs[4] = '{{32'hAA55_1122, 64'h0}, 4, 3, 1'b0, 1'b1, 48'h1234_5678_9ABC};
        vecs[5] = '{{64'hAA55_000A_000B_000C, 32'h0}, 8, -1, 1'b1, 1'b0, 48'h000A_000B_000C};
        vecs[6] = '{{8'h00, 88'h0}, 1, 0, 1'b0, 1'b0, 48'h000A_000B_000C};

        reset   = 1'b0;
        bus.rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_words", {bus.lowest, bus.highest, bus.hitout}, 48'h0);
        check("reset_valid", {47'd0, bus.frame_valid}, 48'd0);
        check("reset_error", {47'd0, bus.frame_error}, 48'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_valid || vecs[i].exp_err) begin
                q.push_back('{vecs[i].exp_err, vecs[i].words});
            end
            for (int k = 0; k < vecs[i].n; k++) begin
                send_byte(vecs[i].bytes[95-8*k -: 8], k != vecs[i].err_at);
            end
            repeat (12 * CPB) @(negedge clk);
            check($sformatf("vec%0d_drained", i), 48'(q.size()), 48'd0);
            check($sformatf("vec%0d_words", i), {bus.lowest, bus.highest, bus.hitout}, vecs[i].words);
            q.delete();
        end

        // Short low glitch between header bytes must not produce a byte.
        q.push_back('{1'b0, 48'h0102_0304_0506});
        send_byte(8'hAA, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        bus.rxd = 1'b0;
        repeat (3) @(negedge clk);
        bus.rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h06, 1'b1);
        repeat (12 * CPB) @(negedge clk);
        check("glitch_drained", 48'(q.size()), 48'd0);
        check("glitch_words", {bus.lowest, bus.highest, bus.hitout}, 48'h0102_0304_0506);
        q.delete();

        // Prior clean frame, then reset in the middle of payload byte 4.
        q.push_back('{1'b0, 48'h1234_5678_9ABC});
        send_frame(64'hAA55_1234_5678_9ABC);
        repeat (4 * CPB) @(negedge clk);
        check("pre_reset_drained", 48'(q.size()), 48'd0);
        q.delete();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        bus.rxd = 1'b0;
        repeat (CPB + CPB / 2) @(negedge clk);
        bus.rxd = 1'b1;
        reset   = 1'b0;
        #1;
        check("midreset_words", {bus.lowest, bus.highest, bus.hitout}, 48'h0);
        check("midreset_valid", {47'd0, bus.frame_valid}, 48'd0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("post_reset_words", {bus.lowest, bus.highest, bus.hitout}, 48'h0);
        q.push_back('{1'b0, 48'hFFFF_0000_8001});
        send_frame(64'hAA55_FFFF_0000_8001);
        repeat (12 * CPB) @(negedge clk);
        check("after_reset_drained", 48'(q.size()), 48'd0);
        check("after_reset_words", {bus.lowest, bus.highest, bus.hitout}, 48'hFFFF_0000_8001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_rx_decoder.md
Name: frame_rx_decoder

Overview:
- Host-side receiving end of the distance telemetry link.
- Deserialises the UART stream (8N1, LSB first, idle high) and hunts for the 16'hAA55 header, sent as 0xAA then 0x55.
- Assembles the following six payload bytes, big-endian per word, into lowest, highest and hitout.
- Presents the three words with a one-cycle frame_valid strobe. Used by the loopback bench and the host-side FPGA.

Parameters:
- CLKS_PER_BIT, 5208: clk cycles per UART bit (50 MHz / 9600 baud); must be >= 8.
- HEADER, 16'hAA55: frame sync word; high byte received first.
- PAYLOAD_BYTES, 6: payload length in bytes; fixed for this frame format.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- rxd  input  1  serial line, asynchronous to clk, idles high.
- lowest  output  16  payload word 0 (bytes 2,3 of the frame).
- highest  output  16  payload word 1 (bytes 4,5 of the frame).
- hitout  output  16  payload word 2 (bytes 6,7 of the frame).
- frame_valid  output  1  one-cycle pulse; the three words are updated in the same cycle.
- frame_error  output  1  one-cycle pulse on a framing error inside a frame.

Behaviour:
- Reset (reset=0, asynchronous): lowest/highest/hitout=0, frame_valid=0, frame_error=0, FSM=HUNT_H, byte receiver idle, synchroniser flops=1.
- rxd passes through a 2-flop synchroniser; all logic uses the synchronised rxd.
- Byte receiver states:
  - IDLE: wait for synced rxd=0.
  - START: count CLKS_PER_BIT/2 cycles and resample. If the line is high, it was a false start: return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. High gives byte_valid; low gives byte_err. Either is a one-cycle pulse, then IDLE.
- The receiver re-arms in IDLE immediately, so back-to-back bytes with no idle gap must decode.
- Frame FSM, advanced only on byte_valid/byte_err:
  - HUNT_H: byte==HEADER[15:8] -> HUNT_L; else stay.
  - HUNT_L: byte==HEADER[7:0] -> PAYLOAD with idx=0. byte==HEADER[15:8] -> stay in HUNT_L (handles AA AA 55). Else -> HUNT_H.
  - PAYLOAD: shift the byte into a 48-bit shadow register and increment idx.
  - On the 6th byte (idx=5), in the cycle after its byte_valid:
    - copy shadow -> {lowest, highest, hitout};
    - pulse frame_valid;
    - go to HUNT_H.
  - Header values inside the payload are data; no resync occurs mid-payload.
- byte_err in HUNT_L or PAYLOAD: pulse frame_error, discard the shadow, go to HUNT_H; outputs hold their previous values.
- byte_err in HUNT_H: ignored (no pulse).
- Outputs change only on frame completion and hold between frames.
- frame_valid and frame_error are never asserted in the same cycle.
- Reset mid-byte or mid-frame aborts everything; the first full frame after reset release decodes normally.
- Latency: frame_valid rises 1 clk after the last stop-bit sample (3 clk after the stop-bit centre on the raw line, including the synchroniser).

Decomposition:
- Shared package frame_pkg holds:
  - FRAME_HEADER=16'hAA55, FRAME_PAYLOAD_BYTES=6;
  - the frame FSM state encoding (HUNT_H, HUNT_L, PAYLOAD);
  - the byte receiver state encoding (IDLE, START, DATA, STOP).
- The encodings are shared with the transmitter bench model.
- One sub-module: uart_byte_rx (synchroniser, bit timing, byte_valid/byte_err). It is reused by other host-side receivers.
- The frame FSM stays in frame_rx_decoder.

Test Plan (CLKS_PER_BIT=16):
- Clean frame: bytes AA 55 12 34 56 78 9A BC, back-to-back -> exactly one frame_valid pulse; lowest=16'h1234, highest=16'h5678, hitout=16'h9ABC.
- Leading garbage and a repeated header byte: 00 FF AA AA 55 00 01 00 02 00 03 -> one frame_valid; outputs 0001/0002/0003.
- Header bytes as payload: AA 55 AA 55 AA 55 AA 55 -> one frame_valid; all three words = 16'hAA55; no early resync.
- Framing error:
  - Stimulus: after the clean frame above, send AA 55 11 22 with the stop bit of 22 driven low.
  - Response: one frame_error pulse, no frame_valid, outputs still 1234/5678/9ABC.
  - A following clean frame AA 55 00 0A 00 0B 00 0C decodes to 000A/000B/000C.
- Glitch rejection: rxd low for 3 clk while idle -> no byte_valid, FSM unchanged; then a clean frame decodes.
- Reset mid-frame:
  - Stimulus: assert reset low during payload byte 4 of AA 55 12 34 56 78 9A BC, after a prior clean frame.
  - Response: outputs=0 immediately (asynchronously) and no frame_valid.
  - After release, frame AA 55 FF FF 00 00 80 01 gives FFFF/0000/8001.
